bk_add_stream: RTL and testbench
================================

Name: bk_add_stream

Overview:
- Streaming wrapper placed directly upstream and downstream of the combinational 12-bit Brent-Kung adder (24-bit interleaved operand bus in, 13-bit sum out).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the adder's interleaved input bus from the FIFO head, registers the adder's 13-bit result, and returns it over a valid/ready handshake.
- Maintains a saturating carry-out event counter for performance monitoring.

Parameters:
- WIDTH, 12, operand width; adder bus is 2*WIDTH, result is WIDTH+1.
- DEPTH, 4, operand FIFO entries; power of two, >= 2.
- CNT_W, 16, carry-event counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- flush  in  1  synchronous clear of FIFO and output register.
- add_inputs  out  2*WIDTH  to adder; bit 2i = A[i], bit 2i+1 = B[i].
- add_outs  in  WIDTH+1  from adder; bit WIDTH = carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  WIDTH+1  registered sum.
- carry_cnt  out  CNT_W  count of delivered results with out_sum[WIDTH]=1.

Behaviour:
- Reset: asynchronous on rst_n low.
  - FIFO pointers and count cleared, in_ready=1.
  - out_valid=0, out_sum=0, carry_cnt=0, add_inputs=0.
  - Reset mid-operation discards all buffered and in-flight pairs; no partial result is emitted after release.
- Push: occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), derived from registered state only.
  - No combinational path from out_ready.
- add_inputs: combinational from the FIFO head entry when count > 0, else all zeros.
  - The adder is combinational, so add_outs is valid in the same cycle.
- Advance: when count > 0 && (!out_valid || out_ready).
  - FIFO pops the head.
  - out_sum <= add_outs; out_valid <= 1.
- Drain: when out_valid && out_ready and no advance, out_valid <= 0 and out_sum holds its last value.
- Simultaneous push and advance: count is unchanged; both operations take effect.
- FIFO full: in_ready=0 while count==DEPTH.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- Latency:
  - A pair accepted in cycle N is presented on add_inputs in cycle N+1.
  - Its result appears on out_sum/out_valid in cycle N+2 when the path is unstalled.
- Throughput: one result per cycle sustained when out_ready=1.
- Ordering: results leave in strict acceptance order; no drop, no duplication.
- Stability: while out_valid && !out_ready, out_sum holds stable.
- carry_cnt:
  - Increments when a result is accepted downstream (out_valid && out_ready) with out_sum[WIDTH]=1.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Not cleared by flush.
- flush: takes priority over push and advance in the same cycle.
  - Clears count and pointers; out_valid <= 0.
  - A handshake on in_valid/in_ready in the flush cycle is discarded.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Test Plan:
- Single pair A=0xFFF, B=0x001, out_ready=1 -> add_inputs=0x555557 in cycle N+1; out_sum=0x1000, out_valid in N+2; carry_cnt=1 after accept.
- Stream A=i, B=2i for i=0..15, out_ready=1 -> out_sum=3i in order, one per cycle; in_ready stays 1; carry_cnt=0.
- out_ready=0, push 5 pairs (0x800+0x800 each) -> first 5 accepted (4 in FIFO + 1 in output register); in_ready=0 afterwards and out_sum=0x1000 held. Then out_ready=1 -> 5 results of 0x1000 and carry_cnt=5.
- Simultaneous push and pop at count=2 over 10 cycles -> count constant at 2; sequence intact.
- Assert rst_n low mid-stream with 3 pairs buffered -> immediate out_valid=0, carry_cnt=0, in_ready=1; no stale results after release.
- flush with in_valid=1 and a pending result -> next cycle out_valid=0 and count=0; flushed pair never emitted; carry_cnt retained.

Source files
------------

// File: rtl/bk_add_stream.sv
// ---------------------------------------------------------------------------
// bk_add_stream
//
// Streaming wrapper around an external combinational WIDTH-bit Brent-Kung
// adder. It buffers operand pairs in a small FIFO, feeds the adder from the
// FIFO head, registers the adder result and returns it downstream. It also
// counts delivered results that carried out, saturating at the counter width.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    FIFO can accept a pair (registered state only)
//   in_a        operand A
//   in_b        operand B
//   flush       synchronous clear of the FIFO and the output register
//   add_inputs  interleaved operand bus to the adder (bit 2i = A[i], 2i+1 = B[i])
//   add_outs    adder result; bit WIDTH is the carry-out
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   out_sum     registered sum
//   carry_cnt   saturating count of delivered results with carry-out set
// ---------------------------------------------------------------------------
module bk_add_stream #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 flush,
    output logic [2*WIDTH-1:0]   add_inputs,
    input  logic [WIDTH:0]       add_outs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum,
    output logic [CNT_W-1:0]     carry_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [WIDTH-1:0]   memA_q [DEPTH];
    logic [WIDTH-1:0]   memB_q [DEPTH];

    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               outValid_q, outValid_d;
    logic [WIDTH:0]     outSum_q, outSum_d;
    logic [CNT_W-1:0]   carryCnt_q, carryCnt_d;

    logic               fifoNotEmpty;
    logic               pushEn;
    logic               advanceEn;
    logic               carryInc;
    logic [WIDTH-1:0]   headA;
    logic [WIDTH-1:0]   headB;
    logic [2*WIDTH-1:0] addInputs;

    // in_ready looks only at the registered count, so a pop in a full cycle
    // frees the slot for the following cycle and out_ready never reaches it.
    assign fifoNotEmpty = (count_q != '0);
    assign in_ready     = (count_q < FULL_COUNT);

    // flush overrides both the upstream handshake and the advance into the
    // output register.
    assign pushEn    = in_valid && in_ready && !flush;
    assign advanceEn = fifoNotEmpty && (!outValid_q || out_ready) && !flush;

    assign headA = memA_q[rdPtr_q];
    assign headB = memB_q[rdPtr_q];

    // Interleave the head pair onto the adder bus; an empty FIFO drives zeros
    // so the adder never sees stale storage.
    always_comb begin
        addInputs = '0;
        if (fifoNotEmpty) begin
            for (int i = 0; i < WIDTH; i++) begin
                addInputs[2*i]   = headA[i];
                addInputs[2*i+1] = headB[i];
            end
        end
    end

    assign add_inputs = addInputs;

    // Operand storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            memA_q[wrPtr_q] <= in_a;
            memB_q[wrPtr_q] <= in_b;
        end
    end

    // Pointer and occupancy next-state. Pointers wrap naturally at DEPTH.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (advanceEn) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            case ({pushEn, advanceEn})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Output register: load on advance, drop valid on a plain drain, and keep
    // the last sum otherwise so it stays stable under backpressure.
    always_comb begin
        outValid_d = outValid_q;
        outSum_d   = outSum_q;
        if (flush) begin
            outValid_d = 1'b0;
            outSum_d   = '0;
        end else if (advanceEn) begin
            outValid_d = 1'b1;
            outSum_d   = add_outs;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Count delivered results with carry-out, holding at all-ones.
    assign carryInc   = outValid_q && out_ready && outSum_q[WIDTH] && (carryCnt_q != '1);
    assign carryCnt_d = carryInc ? (carryCnt_q + CNT_ONE) : carryCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outSum_q   <= '0;
            carryCnt_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            outSum_q   <= outSum_d;
            carryCnt_q <= carryCnt_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_sum   = outSum_q;
    assign carry_cnt = carryCnt_q;

endmodule

// File: tb/tb_bk_add_stream.sv
// ---------------------------------------------------------------------------
// tb_bk_add_stream
//
// Directed bench for bk_add_stream. A behavioural model of the external
// adder de-interleaves add_inputs and returns the 13-bit sum. A second
// instance with a 2-bit carry counter shares all inputs so that counter
// saturation can be observed in a handful of cycles.
// ---------------------------------------------------------------------------
module tb_bk_add_stream;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               flush;
    logic [2*WIDTH-1:0] add_inputs;
    logic [WIDTH:0]     add_outs;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     out_sum;
    logic [CNT_W-1:0]   carry_cnt;

    logic               in_ready2;
    logic [2*WIDTH-1:0] add_inputs2;
    logic [WIDTH:0]     add_outs2;
    logic               out_valid2;
    logic [WIDTH:0]     out_sum2;
    logic [1:0]         carry_cnt2;

    logic [WIDTH-1:0]   modelA, modelB, modelA2, modelB2;

    int testsRun;
    int testsFailed;

    bk_add_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .add_inputs (add_inputs),
        .add_outs   (add_outs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .carry_cnt  (carry_cnt)
    );

    bk_add_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dutSat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .add_inputs (add_inputs2),
        .add_outs   (add_outs2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_sum    (out_sum2),
        .carry_cnt  (carry_cnt2)
    );

    // Behavioural stand-in for the combinational Brent-Kung adders.
    always_comb begin
        modelA  = '0;
        modelB  = '0;
        modelA2 = '0;
        modelB2 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            modelA[i]  = add_inputs[2*i];
            modelB[i]  = add_inputs[2*i+1];
            modelA2[i] = add_inputs2[2*i];
            modelB2[i] = add_inputs2[2*i+1];
        end
        add_outs  = {1'b0, modelA} + {1'b0, modelB};
        add_outs2 = {1'b0, modelA2} + {1'b0, modelB2};
    end

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand generators for the back-to-back test.
    function automatic logic [WIDTH-1:0] pairA(input int j);
        return WIDTH'(j * 341 + 3);
    endfunction

    function automatic logic [WIDTH-1:0] pairB(input int j);
        return WIDTH'(3000 - j * 51);
    endfunction

    // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        nextCycle();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        doReset();
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        testsRun++;
        if (out_sum !== 13'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_sum: got %h expected 0000", out_sum);
        end
        testsRun++;
        if (carry_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_carry_cnt: got %0d expected 0", carry_cnt);
        end
        testsRun++;
        if (add_inputs !== 24'h000000) begin
            testsFailed++;
            $display("[TB] FAIL reset_add_inputs: got %h expected 000000", add_inputs);
        end
    endtask

    task automatic test_single;
        doReset();
        nextCycle();
        in_valid  = 1'b1;
        in_a      = 12'hFFF;
        in_b      = 12'h001;
        out_ready = 1'b1;
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL single_in_ready: got %b expected 1", in_ready);
        end
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (add_inputs !== 24'h555557) begin
            testsFailed++;
            $display("[TB] FAIL single_add_inputs: got %h expected 555557", add_inputs);
        end
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b1 || out_sum !== 13'h1000) begin
            testsFailed++;
            $display("[TB] FAIL single_result: got valid=%b sum=%h expected valid=1 sum=1000",
                     out_valid, out_sum);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (carry_cnt !== 16'd1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_after_accept: got cnt=%0d valid=%b expected cnt=1 valid=0",
                     carry_cnt, out_valid);
        end
    endtask

    task automatic test_stream;
        logic [WIDTH:0] expSum;
        doReset();
        for (int k = 0; k < 18; k++) begin
            nextCycle();
            out_ready = 1'b1;
            in_valid  = (k < 16);
            in_a      = WIDTH'(k);
            in_b      = WIDTH'(2 * k);
            @(negedge clk);
            testsRun++;
            if (in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready);
            end
            if (k >= 2) begin
                expSum = (WIDTH + 1)'(3 * (k - 2));
                testsRun++;
                if (out_valid !== 1'b1 || out_sum !== expSum) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_result[%0d]: got valid=%b sum=%h expected valid=1 sum=%h",
                             k, out_valid, out_sum, expSum);
                end
            end else begin
                testsRun++;
                if (out_valid !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_early_valid[%0d]: got %b expected 0", k, out_valid);
                end
            end
        end
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (carry_cnt !== 16'd0 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stream_end: got cnt=%0d valid=%b expected cnt=0 valid=0",
                     carry_cnt, out_valid);
        end
    endtask

    task automatic test_full;
        int accepted;
        doReset();
        accepted = 0;
        for (int k = 0; k < 7; k++) begin
            nextCycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = 12'h800;
            in_b      = 12'h800;
            @(negedge clk);
            if (in_ready) accepted++;
        end
        testsRun++;
        if (accepted !== 5) begin
            testsFailed++;
            $display("[TB] FAIL full_accepted: got %0d expected 5", accepted);
        end
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 13'h1000) begin
            testsFailed++;
            $display("[TB] FAIL full_hold: got rdy=%b valid=%b sum=%h expected rdy=0 valid=1 sum=1000",
                     in_ready, out_valid, out_sum);
        end
        for (int j = 0; j < 5; j++) begin
            nextCycle();
            out_ready = 1'b1;
            @(negedge clk);
            testsRun++;
            if (out_valid !== 1'b1 || out_sum !== 13'h1000) begin
                testsFailed++;
                $display("[TB] FAIL full_drain[%0d]: got valid=%b sum=%h expected valid=1 sum=1000",
                         j, out_valid, out_sum);
            end
            if (j == 0) begin
                testsRun++;
                if (in_ready !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL full_pop_same_cycle_ready: got %b expected 0", in_ready);
                end
            end
            if (j == 1) begin
                testsRun++;
                if (in_ready !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL full_ready_after_pop: got %b expected 1", in_ready);
                end
            end
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b0 || carry_cnt !== 16'd5) begin
            testsFailed++;
            $display("[TB] FAIL full_end: got valid=%b cnt=%0d expected valid=0 cnt=5",
                     out_valid, carry_cnt);
        end
        testsRun++;
        if (carry_cnt2 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL carry_saturate: got %0d expected 3", carry_cnt2);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0] expSum;
        int expCarries;
        doReset();
        expCarries = 0;
        for (int k = 0; k < 16; k++) begin
            nextCycle();
            out_ready = (k >= 3);
            in_valid  = (k < 13);
            in_a      = pairA(k);
            in_b      = pairB(k);
            @(negedge clk);
            if (k >= 3) begin
                expSum = {1'b0, pairA(k - 3)} + {1'b0, pairB(k - 3)};
                if (expSum[WIDTH]) expCarries++;
                testsRun++;
                if (out_valid !== 1'b1 || out_sum !== expSum) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_result[%0d]: got valid=%b sum=%h expected valid=1 sum=%h",
                             k - 3, out_valid, out_sum, expSum);
                end
                if (k < 13) begin
                    testsRun++;
                    if (in_ready !== 1'b1) begin
                        testsFailed++;
                        $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready);
                    end
                end
            end
        end
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b0 || carry_cnt !== CNT_W'(expCarries)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_end: got valid=%b cnt=%0d expected valid=0 cnt=%0d",
                     out_valid, carry_cnt, expCarries);
        end
    endtask

    task automatic test_reset_mid;
        doReset();
        nextCycle();
        in_valid  = 1'b1;
        in_a      = 12'hFFF;
        in_b      = 12'h001;
        out_ready = 1'b1;
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (carry_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_pre_cnt: got %0d expected 1", carry_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = 12'h800;
            in_b      = 12'h800;
        end
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_pre_state: got valid=%b rdy=%b expected valid=1 rdy=1",
                     out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || carry_cnt !== 16'd0 || in_ready !== 1'b1 || add_inputs !== 24'h0) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_async: got valid=%b cnt=%0d rdy=%b bus=%h expected 0 0 1 000000",
                     out_valid, carry_cnt, in_ready, add_inputs);
        end
        nextCycle();
        out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            @(negedge clk);
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rstmid_stale[%0d]: got %b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_flush;
        doReset();
        nextCycle();
        in_valid  = 1'b1;
        in_a      = 12'hFFF;
        in_b      = 12'h001;
        out_ready = 1'b1;
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        nextCycle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 12'h800;
        in_b      = 12'h800;
        @(negedge clk);
        testsRun++;
        if (carry_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL flush_pre_cnt: got %0d expected 1", carry_cnt);
        end
        nextCycle();
        in_a = 12'h010;
        in_b = 12'h020;
        nextCycle();
        flush = 1'b1;
        in_a  = 12'h111;
        in_b  = 12'h222;
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b1 || out_sum !== 13'h1000) begin
            testsFailed++;
            $display("[TB] FAIL flush_pending: got valid=%b sum=%h expected valid=1 sum=1000",
                     out_valid, out_sum);
        end
        nextCycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_inputs !== 24'h0 || carry_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL flush_after: got valid=%b rdy=%b bus=%h cnt=%0d expected 0 1 000000 1",
                     out_valid, in_ready, add_inputs, carry_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            @(negedge clk);
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL flush_stale[%0d]: got %b expected 0", k, out_valid);
            end
        end
        nextCycle();
        in_valid = 1'b1;
        in_a     = 12'h123;
        in_b     = 12'h456;
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (out_valid !== 1'b1 || out_sum !== 13'h0579) begin
            testsFailed++;
            $display("[TB] FAIL flush_resume: got valid=%b sum=%h expected valid=1 sum=0579",
                     out_valid, out_sum);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (carry_cnt !== 16'd1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_end: got cnt=%0d valid=%b expected cnt=1 valid=0",
                     carry_cnt, out_valid);
        end
    endtask

    // Test sequence
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        test_reset();
        test_single();
        test_stream();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_flush();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
